// File: rtl/seg7_pkg.sv
// Shared types and constants for the 4-digit 7-segment scan driver.
package seg7_pkg;
    localparam int NUM_DIGITS  = 4;
    localparam int DIGIT_W     = 4;
    localparam int DIGIT_IDX_W = 2;
    localparam int DATA_W      = 16;

    typedef logic [DIGIT_IDX_W-1:0] digit_idx_t;
    typedef logic [DIGIT_W-1:0]     nibble_t;

    // One display image: the hex word plus its decimal-point bits
    typedef struct packed {
        logic [DATA_W-1:0]     word;
        logic [NUM_DIGITS-1:0] dots;
    } disp_buf_t;

    // Select the nibble belonging to digit idx (digit 0 is the low nibble)
    function automatic nibble_t get_nibble(input logic [DATA_W-1:0] w, input digit_idx_t idx);
        return w[DIGIT_W*idx +: DIGIT_W];
    endfunction
endpackage

// File: rtl/seg7_prescaler.sv
// Slot-rate prescaler: emits a one-cycle tick every SCAN_DIV enabled cycles.
// The tick is combinational on the terminal count so SCAN_DIV=1 ticks every cycle.
module seg7_prescaler #(
    parameter int SCAN_DIV = 100000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic ENABLE_IN,
    output logic TICK_OUT
);
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] cnt;

    assign TICK_OUT = ENABLE_IN && (cnt == LAST);

    // Count while enabled, hold while disabled, restart after the terminal count
    always_ff @(posedge CLK) begin
        if (!RESET)
            cnt <= '0;
        else if (ENABLE_IN)
            cnt <= TICK_OUT ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed scan controller for a 4-digit 7-segment display.
// Loads land in a shadow buffer and are committed to the active image only at a
// frame wrap (or immediately while blanked), so a frame never mixes old and new digits.
// Optional: define SEG7_LEADING_ZERO_BLANK_EN to blank leading zero digits.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV = 100000
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [DATA_W-1:0]     DATA_IN,
    input  logic [NUM_DIGITS-1:0] DOT_MASK_IN,
    input  logic                  LOAD_IN,
    input  logic                  ENABLE_IN,
    output logic [DIGIT_IDX_W-1:0] SEG_SELECT_OUT,
    output logic [DIGIT_W-1:0]    BIN_OUT,
    output logic                  DOT_OUT,
    output logic                  BLANK_OUT,
    output logic                  PENDING_OUT,
    output logic                  FRAME_TICK_OUT
);
    localparam digit_idx_t LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

    digit_idx_t idx;
    disp_buf_t  active, shadow;
    logic       pending, frame_tick;
    logic       tick, wrap, commit;
    logic [NUM_DIGITS-1:0] lz_blank;

    seg7_prescaler #(.SCAN_DIV(SCAN_DIV)) u_presc (
        .CLK       (CLK),
        .RESET     (RESET),
        .ENABLE_IN (ENABLE_IN),
        .TICK_OUT  (tick)
    );

    assign wrap   = tick && (idx == LAST_IDX);
    // While blanked nothing is visible, so a pending image can go live at once
    assign commit = pending && (wrap || !ENABLE_IN);

    // Scan index, double buffer and frame pulse
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            idx        <= '0;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap;
            if (tick)
                idx <= idx + 1'b1;
            // active takes the pre-edge shadow; a coincident load stays pending
            if (commit)
                active <= shadow;
            if (LOAD_IN) begin
                shadow  <= '{word: DATA_IN, dots: DOT_MASK_IN};
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // Digit g goes dark when it and every digit above it are zero and its own dot is off
    assign lz_blank[0] = 1'b0;
    for (genvar g = 1; g < NUM_DIGITS; g++) begin : g_lz
        assign lz_blank[g] = (active.word[DATA_W-1:DIGIT_W*g] == '0) && !active.dots[g];
    end
`else
    assign lz_blank = '0;
`endif

    assign SEG_SELECT_OUT = idx;
    assign BIN_OUT        = get_nibble(active.word, idx);
    assign DOT_OUT        = active.dots[idx];
    assign BLANK_OUT      = !ENABLE_IN || lz_blank[idx];
    assign PENDING_OUT    = pending;
    assign FRAME_TICK_OUT = frame_tick;
endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexing scan controller for the Basys2 4-digit 7-segment display.
- Sits upstream of the combinational segment decoder and drives its digit-select, nibble and dot inputs.
- Holds a 16-bit display word plus 4 dot bits and cycles through the digits at a prescaled rate.
- New values are double-buffered and committed only at frame boundaries, so a frame never mixes old and new digits.

Parameters:
- SCAN_DIV, 100000, CLK cycles per digit slot; 50 MHz gives 500 Hz per digit and a 125 Hz frame rate; legal range >= 1.

Ports:
- CLK  input  1  system clock; all logic on the rising edge.
- RESET  input  1  synchronous, active-low reset.
- DATA_IN  input  16  display word; [3:0] is digit 0 (rightmost), [15:12] is digit 3 (leftmost).
- DOT_MASK_IN  input  4  decimal-point bit per digit; bit i belongs to digit i.
- LOAD_IN  input  1  single-cycle strobe that captures DATA_IN and DOT_MASK_IN into the shadow buffer.
- ENABLE_IN  input  1  1 = scanning; 0 = display blanked and scan frozen.
- SEG_SELECT_OUT  output  2  current digit index, 0..3.
- BIN_OUT  output  4  active nibble for the current digit.
- DOT_OUT  output  1  dot bit for the current digit; active-high.
- BLANK_OUT  output  1  1 = top level forces all anodes off.
- PENDING_OUT  output  1  1 = shadow holds data not yet committed.
- FRAME_TICK_OUT  output  1  one-cycle pulse on each commit/wrap edge.

Behaviour:
- Reset (RESET=0 at a CLK edge) clears: prescaler count, digit index, active word/dots, shadow word/dots, pending flag, FRAME_TICK_OUT.
  - After reset: SEG_SELECT_OUT=0, BIN_OUT=0, DOT_OUT=0, PENDING_OUT=0, FRAME_TICK_OUT=0.
  - BLANK_OUT=~ENABLE_IN (combinational).
  - Reset mid-frame discards pending data.
- Prescaler counts 0..SCAN_DIV-1 only while ENABLE_IN=1.
  - At count SCAN_DIV-1, a slot tick occurs and the count returns to 0.
  - SCAN_DIV=1 gives a tick every cycle.
- On a slot tick, the digit index increments modulo 4.
  - Wrap event: index goes 3->0.
  - On the wrap edge, if pending=1: active <= shadow contents as they were before this edge, and pending <= 0.
  - FRAME_TICK_OUT=1 for exactly the cycle after every wrap edge, whether or not a commit happened.
- LOAD_IN=1: shadow <= DATA_IN/DOT_MASK_IN and pending <= 1.
  - If LOAD_IN coincides with a wrap commit, active takes the old shadow and pending stays 1; the new data commits at the next wrap.
  - Multiple loads before a wrap: the last one wins.
- ENABLE_IN=0: prescaler and index hold, BLANK_OUT=1.
  - A pending shadow commits on the next CLK edge; there is no tearing risk while blanked.
  - FRAME_TICK_OUT does not pulse.
- Outputs are combinational from registered state, with zero added latency:
  - BIN_OUT = active[4*idx +: 4]
  - DOT_OUT = active_dots[idx]
  - SEG_SELECT_OUT changes on the same edge as the index register.
- Index width is 2 bits and wraps naturally; no out-of-range states exist.

Optional Feature:
- Macro: SEG7_LEADING_ZERO_BLANK_EN.
- Defined: digit i (i=1..3) is blanked (BLANK_OUT=1 during its slot) when:
  - its nibble is 0,
  - all higher nibbles are 0,
  - its dot bit is 0.
  - Digit 0 is never blanked by this rule.
- Undefined: BLANK_OUT=~ENABLE_IN only; all four digits are always shown.

Decomposition:
- Package seg7_pkg:
  - NUM_DIGITS=4, DIGIT_W=4, DIGIT_IDX_W=2, DATA_W=16
  - typedef digit_idx_t (2-bit)
  - typedef nibble_t (4-bit)
- Sub-module seg7_prescaler:
  - Parameter SCAN_DIV.
  - Inputs CLK, RESET, ENABLE_IN; output 1-cycle TICK_OUT.
  - Count held when disabled, cleared on reset.

Test Plan (SCAN_DIV=4):
- Reset: hold RESET=0 for 3 cycles while pulsing LOAD_IN with 16'hFFFF -> after release, SEG_SELECT_OUT=0, BIN_OUT=0, DOT_OUT=0, PENDING_OUT=0; first slot tick after 4 enabled cycles.
- Basic scan: LOAD 16'h1234 with dots 4'b0010 mid-frame -> PENDING_OUT=1 until the wrap edge; FRAME_TICK_OUT pulses once; then BIN_OUT reads 4,3,2,1 at idx 0..3, each for 4 cycles; DOT_OUT=1 only at idx 1.
- Last-wins/coincident: LOAD 16'hABCD, then LOAD 16'hEF01 before the wrap -> only EF01 is displayed. Separately, LOAD 16'h7777 on the wrap-edge cycle -> old shadow commits, PENDING_OUT stays 1, and 7777 appears after the following wrap.
- Disable: drop ENABLE_IN for 10 cycles at idx 2 -> BLANK_OUT=1, idx holds at 2, no FRAME_TICK_OUT; LOAD 16'h5555 -> committed next cycle with PENDING_OUT=0; re-enable -> resumes from idx 2 with the prescaler count preserved.
- Reset mid-frame: RESET=0 at idx 3 with PENDING_OUT=1 -> idx=0, active=0, PENDING_OUT=0 on the next edge.
- Leading-zero blank (macro defined):
  - 16'h0042 -> BLANK_OUT=1 at idx 3 and 2; digits 0 and 1 shown.
  - 16'h0000 -> only idx 0 shown.
  - 16'h0000 with dots 4'b1000 -> idx 3 shown, idx 1 and 2 blanked (a dot keeps only its own digit lit, it does not stop blanking of lower digits).
